montgomery_ctrl: RTL

- Sequencer for the shared multi-cycle 514-bit adder (add/subtract/shift-by-one, start/done handshake).
- Computes the Montgomery product `result = A*B*2^-N mod M` by bit-serial interleaved add-and-shift, then one conditional final subtraction.
- Sits between the RSA top-level exponentiation FSM and the adder instance; the adder is instantiated beside it in the parent, not inside.

---
 rtl/montgomery_ctrl_pkg.sv | 19 +
 rtl/montgomery_ctrl_if.sv | 24 ++
 rtl/montgomery_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/montgomery_ctrl_pkg.sv
// Shared constants and state encoding for the Montgomery multiplier sequencer.
package montgomery_pkg;

    localparam int N_BITS = 512;
    localparam int ADD_W  = N_BITS + 2;
    localparam int IDX_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_B,
        WAIT_B,
        ISSUE_M,
        WAIT_M,
        ISSUE_SUB,
        WAIT_SUB,
        DONE
    } state_t;

endpackage

// File: rtl/montgomery_ctrl_if.sv
// Request/response bus between the Montgomery sequencer and the shared multi-cycle adder.
interface montgomery_ctrl_if #(
    parameter int ADD_W = montgomery_pkg::ADD_W
);

    logic             add_start;
    logic             add_subtract;
    logic             add_shift;
    logic [ADD_W-1:0] add_in_a;
    logic [ADD_W-1:0] add_in_b;
    logic [ADD_W:0]   add_result;
    logic             add_done;

    modport master (
        output add_start, add_subtract, add_shift, add_in_a, add_in_b,
        input  add_result, add_done
    );

    modport slave (
        input  add_start, add_subtract, add_shift, add_in_a, add_in_b,
        output add_result, add_done
    );

endinterface

// File: rtl/montgomery_ctrl.sv
// Bit-serial Montgomery product A*B*2^-N mod M, driving an external shared adder
// through add/shift steps and one conditional final subtraction.
module montgomery_ctrl #(
    parameter int N_BITS = montgomery_pkg::N_BITS,
    parameter int ADD_W  = N_BITS + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] in_a,
    input  logic [N_BITS-1:0] in_b,
    input  logic [N_BITS-1:0] in_m,
    output logic [N_BITS-1:0] result,
    output logic              done,
    output logic              busy,
    montgomery_ctrl_if.master add_bus
);
    import montgomery_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);

    state_t            state_reg, state_next;
    logic [N_BITS-1:0] a_reg, a_next, b_reg, b_next, m_reg, m_next;
    logic [N_BITS-1:0] result_reg, result_next;
    logic [ADD_W-1:0]  c_reg, c_next;
    logic [IDX_W-1:0]  i_reg, i_next;
    logic [ADD_W-1:0]  op_a_reg, op_a_next, op_b_reg, op_b_next;
    logic              sub_reg, sub_next, shift_reg, shift_next;
    logic              add_start_reg, done_reg, busy_reg;
    logic              a_bit;
    logic              add_carry;
    logic [ADD_W-1:0]  add_sum;

    assign add_carry = add_bus.add_result[ADD_W];
    assign add_sum   = add_bus.add_result[ADD_W-1:0];
    assign a_bit     = |(a_next & (N_BITS'(1) << i_next));

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        m_next      = m_reg;
        c_next      = c_reg;
        i_next      = i_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = in_a;
                    b_next     = in_b;
                    m_next     = in_m;
                    c_next     = '0;
                    i_next     = '0;
                    state_next = ISSUE_B;
                end
            end
            ISSUE_B: state_next = WAIT_B;
            WAIT_B: begin
                if (add_bus.add_done) begin
                    c_next     = add_sum;
                    state_next = ISSUE_M;
                end
            end
            ISSUE_M: state_next = WAIT_M;
            WAIT_M: begin
                if (add_bus.add_done) begin
                    c_next = add_sum;
                    if (i_reg == LAST_IDX) begin
                        state_next = ISSUE_SUB;
                    end else begin
                        i_next     = i_reg + IDX_W'(1);
                        state_next = ISSUE_B;
                    end
                end
            end
            ISSUE_SUB: state_next = WAIT_SUB;
            WAIT_SUB: begin
                if (add_bus.add_done) begin
                    // Carry-out of the subtract means C >= M, so the difference is the reduced value.
                    result_next = add_carry ? add_sum[N_BITS-1:0] : c_reg[N_BITS-1:0];
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are loaded on entry to each issue state and then held until the
    // adder reports done, so the adder may sample them on any cycle of the op.
    always_comb begin
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        sub_next   = sub_reg;
        shift_next = shift_reg;
        case (state_next)
            ISSUE_B: begin
                op_a_next  = c_next;
                op_b_next  = a_bit ? ADD_W'(b_next) : '0;
                sub_next   = 1'b0;
                shift_next = 1'b0;
            end
            ISSUE_M: begin
                op_a_next  = c_next;
                op_b_next  = c_next[0] ? ADD_W'(m_reg) : '0;
                sub_next   = 1'b0;
                shift_next = 1'b1;
            end
            ISSUE_SUB: begin
                op_a_next  = c_next;
                op_b_next  = ADD_W'(m_reg);
                sub_next   = 1'b1;
                shift_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            m_reg         <= '0;
            c_reg         <= '0;
            i_reg         <= '0;
            result_reg    <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            sub_reg       <= 1'b0;
            shift_reg     <= 1'b0;
            add_start_reg <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            m_reg         <= m_next;
            c_reg         <= c_next;
            i_reg         <= i_next;
            result_reg    <= result_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            sub_reg       <= sub_next;
            shift_reg     <= shift_next;
            add_start_reg <= (state_next == ISSUE_B) || (state_next == ISSUE_M) ||
                             (state_next == ISSUE_SUB);
            done_reg      <= (state_next == DONE);
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign result               = result_reg;
    assign done                 = done_reg;
    assign busy                 = busy_reg;
    assign add_bus.add_start    = add_start_reg;
    assign add_bus.add_subtract = sub_reg;
    assign add_bus.add_shift    = shift_reg;
    assign add_bus.add_in_a     = op_a_reg;
    assign add_bus.add_in_b     = op_b_reg;

endmodule
